// File: rtl/alu_operand_regfile_if.sv
// Operand-stage bus bundle: register selects, write-back and load ports,
// plus the registered A/B operand outputs.
interface alu_operand_regfile_if #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned MEM_W  = 8
);
  logic [SEL_W-1:0]  A_SEL;
  logic [SEL_W-1:0]  B_SEL;
  logic              IMM_EN;
  logic [IMM_W-1:0]  IMM;
  logic              WR_EN;
  logic [SEL_W-1:0]  WR_SEL;
  logic [DATA_W-1:0] alu_out;
  logic              LD_EN;
  logic [SEL_W-1:0]  LD_SEL;
  logic [MEM_W-1:0]  LD_DATA;
  logic [DATA_W-1:0] a_bus;
  logic [DATA_W-1:0] b_bus;
  logic              ops_vld;

  modport master (
    output A_SEL, B_SEL, IMM_EN, IMM, WR_EN, WR_SEL, alu_out, LD_EN, LD_SEL, LD_DATA,
    input  a_bus, b_bus, ops_vld
  );

  modport slave (
    input  A_SEL, B_SEL, IMM_EN, IMM, WR_EN, WR_SEL, alu_out, LD_EN, LD_SEL, LD_DATA,
    output a_bus, b_bus, ops_vld
  );
endinterface

// File: rtl/alu_operand_regfile.sv
// General register file with write-first forwarding and registered ALU
// operand buses. R0 reads as zero and ignores writes.
module alu_operand_regfile #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned NREG   = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned IMM_W  = 8,
  parameter int unsigned MEM_W  = 8
) (
  input logic                 clk,
  input logic                 RST,
  alu_operand_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] a_bus_q, a_bus_d;
  logic [DATA_W-1:0] b_bus_q, b_bus_d;
  logic              ops_vld_q;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] imm_ext;

  assign ld_ext  = {{(DATA_W-MEM_W){1'b0}}, bus.LD_DATA};
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.IMM};

  // Next register contents double as the forwarded read value: ALU write
  // overrides a colliding load, and R0 is forced to zero.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      if (bus.LD_EN && (bus.LD_SEL == SEL_W'(r))) begin
        regs_d[r] = ld_ext;
      end
      if (bus.WR_EN && (bus.WR_SEL == SEL_W'(r))) begin
        regs_d[r] = bus.alu_out;
      end
    end
    regs_d[0] = '0;
  end

  always_comb begin
    a_bus_d = regs_d[bus.A_SEL];
    b_bus_d = bus.IMM_EN ? imm_ext : regs_d[bus.B_SEL];
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      a_bus_q   <= '0;
      b_bus_q   <= '0;
      ops_vld_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      a_bus_q   <= a_bus_d;
      b_bus_q   <= b_bus_d;
      ops_vld_q <= 1'b1;
    end
  end

  assign bus.a_bus   = a_bus_q;
  assign bus.b_bus   = b_bus_q;
  assign bus.ops_vld = ops_vld_q;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed-vector bench for alu_operand_regfile with hand-computed expectations.
module tb_alu_operand_regfile;

  logic clk;
  logic RST;
  int   vectors;
  int   miscompares;

  alu_operand_regfile_if #(.DATA_W(19), .SEL_W(3), .IMM_W(8), .MEM_W(8)) ifc ();

  alu_operand_regfile #(
    .DATA_W(19), .NREG(8), .SEL_W(3), .IMM_W(8), .MEM_W(8)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.A_SEL   = '0;
    ifc.B_SEL   = '0;
    ifc.IMM_EN  = 1'b0;
    ifc.IMM     = '0;
    ifc.WR_EN   = 1'b0;
    ifc.WR_SEL  = '0;
    ifc.alu_out = '0;
    ifc.LD_EN   = 1'b0;
    ifc.LD_SEL  = '0;
    ifc.LD_DATA = '0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    idle_inputs();
    #12;
    vectors++;
    if (ifc.a_bus !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_a_bus: got %h want %h", ifc.a_bus, 19'h0);
    end
    vectors++;
    if (ifc.b_bus !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_b_bus: got %h want %h", ifc.b_bus, 19'h0);
    end
    vectors++;
    if (ifc.ops_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ops_vld: got %b want %b", ifc.ops_vld, 1'b0);
    end
    RST = 1'b1;
    step();
    vectors++;
    if (ifc.ops_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge_ops_vld: got %b want %b", ifc.ops_vld, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    ifc.LD_EN   = 1'b1;
    ifc.LD_SEL  = 3'd3;
    ifc.LD_DATA = 8'h55;
    step();
    idle_inputs();
    ifc.A_SEL = 3'd3;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h00055) begin
      miscompares++;
      $display("FAIL r3_loaded: got %h want %h", ifc.a_bus, 19'h00055);
    end
    // Pending write to R3 that the reset must discard.
    ifc.WR_EN   = 1'b1;
    ifc.WR_SEL  = 3'd3;
    ifc.alu_out = 19'h00099;
    #2;
    RST = 1'b0;
    #1;
    vectors++;
    if (ifc.a_bus !== 19'h0 || ifc.b_bus !== 19'h0 || ifc.ops_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got a=%h b=%h v=%b want 0 0 0",
               ifc.a_bus, ifc.b_bus, ifc.ops_vld);
    end
    idle_inputs();
    ifc.A_SEL = 3'd3;
    #2;
    RST = 1'b1;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h0) begin
      miscompares++;
      $display("FAIL r3_after_reset: got %h want %h", ifc.a_bus, 19'h0);
    end
  endtask

  task automatic test_load();
    idle_inputs();
    ifc.LD_EN   = 1'b1;
    ifc.LD_SEL  = 3'd2;
    ifc.LD_DATA = 8'hA7;
    step();
    idle_inputs();
    ifc.A_SEL = 3'd2;
    ifc.B_SEL = 3'd2;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h000A7) begin
      miscompares++;
      $display("FAIL load_read_a: got %h want %h", ifc.a_bus, 19'h000A7);
    end
    vectors++;
    if (ifc.b_bus !== 19'h000A7) begin
      miscompares++;
      $display("FAIL load_read_b: got %h want %h", ifc.b_bus, 19'h000A7);
    end
    // Load forwarding onto b_bus on the same edge.
    ifc.LD_EN   = 1'b1;
    ifc.LD_SEL  = 3'd7;
    ifc.LD_DATA = 8'h3C;
    ifc.B_SEL   = 3'd7;
    step();
    vectors++;
    if (ifc.b_bus !== 19'h0003C) begin
      miscompares++;
      $display("FAIL load_forward_b: got %h want %h", ifc.b_bus, 19'h0003C);
    end
  endtask

  task automatic test_forward();
    idle_inputs();
    ifc.WR_EN   = 1'b1;
    ifc.WR_SEL  = 3'd4;
    ifc.alu_out = 19'h7FFFF;
    ifc.A_SEL   = 3'd4;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h7FFFF) begin
      miscompares++;
      $display("FAIL wr_forward_a: got %h want %h", ifc.a_bus, 19'h7FFFF);
    end
    idle_inputs();
    ifc.A_SEL = 3'd4;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h7FFFF) begin
      miscompares++;
      $display("FAIL wr_stored_a: got %h want %h", ifc.a_bus, 19'h7FFFF);
    end
  endtask

  task automatic test_imm_r0();
    idle_inputs();
    ifc.IMM_EN = 1'b1;
    ifc.IMM    = 8'hFF;
    ifc.B_SEL  = 3'd4;
    step();
    vectors++;
    if (ifc.b_bus !== 19'h000FF) begin
      miscompares++;
      $display("FAIL imm_b_bus: got %h want %h", ifc.b_bus, 19'h000FF);
    end
    idle_inputs();
    ifc.WR_EN   = 1'b1;
    ifc.WR_SEL  = 3'd0;
    ifc.alu_out = 19'h12345;
    ifc.LD_EN   = 1'b1;
    ifc.LD_SEL  = 3'd0;
    ifc.LD_DATA = 8'hEE;
    ifc.A_SEL   = 3'd0;
    ifc.B_SEL   = 3'd0;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h0 || ifc.b_bus !== 19'h0) begin
      miscompares++;
      $display("FAIL r0_write_same_edge: got a=%h b=%h want 0 0", ifc.a_bus, ifc.b_bus);
    end
    idle_inputs();
    step();
    vectors++;
    if (ifc.a_bus !== 19'h0) begin
      miscompares++;
      $display("FAIL r0_read_after: got %h want %h", ifc.a_bus, 19'h0);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    ifc.WR_EN   = 1'b1;
    ifc.WR_SEL  = 3'd5;
    ifc.alu_out = 19'h00010;
    ifc.LD_EN   = 1'b1;
    ifc.LD_SEL  = 3'd5;
    ifc.LD_DATA = 8'h20;
    ifc.A_SEL   = 3'd5;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h00010) begin
      miscompares++;
      $display("FAIL collision_forward: got %h want %h", ifc.a_bus, 19'h00010);
    end
    idle_inputs();
    ifc.B_SEL = 3'd5;
    step();
    vectors++;
    if (ifc.b_bus !== 19'h00010) begin
      miscompares++;
      $display("FAIL collision_stored: got %h want %h", ifc.b_bus, 19'h00010);
    end
  endtask

  task automatic test_dual_write();
    idle_inputs();
    ifc.WR_EN   = 1'b1;
    ifc.WR_SEL  = 3'd5;
    ifc.alu_out = 19'h1ABCD;
    ifc.LD_EN   = 1'b1;
    ifc.LD_SEL  = 3'd6;
    ifc.LD_DATA = 8'h99;
    step();
    idle_inputs();
    ifc.A_SEL = 3'd5;
    ifc.B_SEL = 3'd6;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h1ABCD) begin
      miscompares++;
      $display("FAIL dual_wr_r5: got %h want %h", ifc.a_bus, 19'h1ABCD);
    end
    vectors++;
    if (ifc.b_bus !== 19'h00099) begin
      miscompares++;
      $display("FAIL dual_ld_r6: got %h want %h", ifc.b_bus, 19'h00099);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    ifc.A_SEL = 3'd1;
    step();
    vectors++;
    if (ifc.a_bus !== 19'h0) begin
      miscompares++;
      $display("FAIL incr_start: got %h want %h", ifc.a_bus, 19'h0);
    end
    for (int i = 0; i < 10; i++) begin
      ifc.WR_EN   = 1'b1;
      ifc.WR_SEL  = 3'd1;
      ifc.alu_out = ifc.a_bus + 19'd1;
      step();
      vectors++;
      if (ifc.a_bus !== 19'(i + 1)) begin
        miscompares++;
        $display("FAIL incr_iter%0d: got %h want %h", i, ifc.a_bus, 19'(i + 1));
      end
    end
    idle_inputs();
    ifc.B_SEL = 3'd1;
    step();
    vectors++;
    if (ifc.b_bus !== 19'd10) begin
      miscompares++;
      $display("FAIL incr_final_r1: got %h want %h", ifc.b_bus, 19'd10);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_reset_mid();
    test_load();
    test_forward();
    test_imm_r0();
    test_collision();
    test_dual_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
